// File: rtl/tron_trail_mem_responder_if.sv
// Request/response bundle between a trail-grid client and tron_trail_mem_responder.
interface tron_trail_mem_responder_if;
  logic [22:0] req_addr;
  logic        req_re;
  logic        req_we;
  logic [15:0] req_wdata;
  logic        clear;
  logic [15:0] rsp_rdata;
  logic        rsp_valid;
  logic        busy;
  logic        clear_done;

  modport master (
    output req_addr, req_re, req_we, req_wdata, clear,
    input  rsp_rdata, rsp_valid, busy, clear_done
  );

  modport slave (
    input  req_addr, req_re, req_we, req_wdata, clear,
    output rsp_rdata, rsp_valid, busy, clear_done
  );
endinterface

// File: rtl/tron_trail_mem_responder.sv
// Trail grid memory: 2-bit owner per cell, fixed-latency collision reads, posted writes.
// Define TRON_MEM_CLEAR_EN to build the grid-erase sweep (also run on every reset exit).
//
//   state   | meaning
//   IDLE    | accepting requests, busy=0
//   RD_WAIT | read accepted, counting down to the response cycle
//   RESP    | rsp_valid cycle
//   CLEAR   | sweeping zeros into the grid, one cell per cycle
module tron_trail_mem_responder #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned X_MAX        = 160,
  parameter int unsigned Y_MAX        = 120
) (
  input  logic                          clk,
  input  logic                          resetn,
  tron_trail_mem_responder_if.slave     bus
);
  localparam int unsigned DEPTH = X_MAX * Y_MAX;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, CLEAR} state_t;

  state_t          state;
  logic [1:0]      mem [DEPTH];

  logic [7:0]      x;
  logic [6:0]      y;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [1:0]      rd_word;
  logic            accept;
  logic            rd_accept;

  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [1:0]      ram_wdata;

  logic [2:0]      lat_cnt;
  logic [1:0]      rd_q;
  logic [15:0]     rsp_rdata_q;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            unused_bits;

`ifdef TRON_MEM_CLEAR_EN
  logic [AW-1:0]   sweep_idx;
  logic            clear_pend;
  logic            clear_done_q;
  assign unused_bits = ^bus.req_wdata[15:2];
`else
  assign unused_bits = ^{bus.req_wdata[15:2], bus.clear};
`endif

  always_comb begin
    x         = bus.req_addr[14:7];
    y         = bus.req_addr[6:0];
    in_range  = (bus.req_addr[22:15] == 8'd0) && (32'(x) < X_MAX) && (32'(y) < Y_MAX);
    idx       = AW'(32'(y) * X_MAX + 32'(x));
    // Anything off the grid reads back as a wall (owner 1).
    rd_word   = in_range ? mem[idx] : 2'b01;
    accept    = (state == IDLE) && (bus.req_re || bus.req_we);
    rd_accept = accept && bus.req_re;
    ram_we    = 1'b0;
    ram_waddr = idx;
    ram_wdata = bus.req_wdata[1:0];
    if (resetn) begin
      if (accept && bus.req_we && in_range) ram_we = 1'b1;
`ifdef TRON_MEM_CLEAR_EN
      if (state == CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = sweep_idx;
        ram_wdata = 2'b00;
      end
`endif
    end
  end

  // RAM carries no reset; only the sweep erases it.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_rdata_q  <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      lat_cnt      <= 3'd0;
      rd_q         <= 2'b00;
`ifdef TRON_MEM_CLEAR_EN
      state        <= CLEAR;
      busy_q       <= 1'b1;
      sweep_idx    <= '0;
      clear_pend   <= 1'b0;
      clear_done_q <= 1'b0;
`else
      state        <= IDLE;
      busy_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef TRON_MEM_CLEAR_EN
      clear_done_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rd_accept) begin
            rd_q   <= rd_word;
            busy_q <= 1'b1;
`ifdef TRON_MEM_CLEAR_EN
            clear_pend <= bus.clear;
`endif
            if (READ_LATENCY == 1) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= {14'b0, rd_word};
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= 3'(READ_LATENCY - 2);
            end
          end
`ifdef TRON_MEM_CLEAR_EN
          else if (bus.clear) begin
            state     <= CLEAR;
            busy_q    <= 1'b1;
            sweep_idx <= '0;
          end
`endif
        end
        RD_WAIT: begin
`ifdef TRON_MEM_CLEAR_EN
          if (bus.clear) clear_pend <= 1'b1;
`endif
          if (lat_cnt == 3'd0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= {14'b0, rd_q};
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
`ifdef TRON_MEM_CLEAR_EN
          if (clear_pend || bus.clear) begin
            state      <= CLEAR;
            busy_q     <= 1'b1;
            sweep_idx  <= '0;
            clear_pend <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
`else
          state  <= IDLE;
          busy_q <= 1'b0;
`endif
        end
        CLEAR: begin
`ifdef TRON_MEM_CLEAR_EN
          if (sweep_idx == AW'(DEPTH - 1)) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
`else
          state  <= IDLE;
          busy_q <= 1'b0;
`endif
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = busy_q;
`ifdef TRON_MEM_CLEAR_EN
  assign bus.clear_done = clear_done_q;
`else
  assign bus.clear_done = 1'b0;
`endif
endmodule

// File: doc/tron_trail_mem_responder.md
TRON_TRAIL_MEM_RESPONDER -- requirements
Module: tron_trail_mem_responder

Interface
REQ-001 Parameter: READ_LATENCY, default 2, cycles from request accept to rsp_valid (legal 1..7).
REQ-002 Parameter: X_MAX, default 160, grid width in cells.
REQ-003 Parameter: Y_MAX, default 120, grid height in cells.
REQ-004 The block SHALL use reset resetn, synchronous, active-low, and clock clk.
REQ-005 Port: clk  input  1  system clock, all logic on rising edge.
REQ-006 Port: resetn  input  1  synchronous active-low reset.
REQ-007 Port: req_addr  input  23  cell address; x = [14:7], y = [6:0], [22:15] must be zero.
REQ-008 Port: req_re  input  1  read request (collision check).
REQ-009 Port: req_we  input  1  write request (trail mark).
REQ-010 Port: req_wdata  input  16  write data; only [1:0] (owner id) stored.
REQ-011 Port: clear  input  1  one-cycle request to erase the grid.
REQ-012 Port: rsp_rdata  output  16  read data, {14'b0, owner id}.
REQ-013 Port: rsp_valid  output  1  one-cycle pulse, rsp_rdata valid.
REQ-014 Port: busy  output  1  high = requests ignored.
REQ-015 Port: clear_done  output  1  one-cycle pulse at end of grid sweep.

Function
REQ-016 Storage SHALL be X_MAX*Y_MAX cells of 2 bits in on-chip RAM, index = y*X_MAX + x.
REQ-017 A request SHALL be accepted on a rising edge where busy=0 and (req_re or req_we)=1; requests while busy=1 are dropped, not queued.
REQ-018 States: IDLE, RD_WAIT, RESP, CLEAR; IDLE->RD_WAIT on accepted read, RD_WAIT->RESP after READ_LATENCY-1 cycles, RESP->IDLE after one cycle, IDLE->CLEAR on clear (with macro).
REQ-019 Read: rsp_valid SHALL pulse exactly READ_LATENCY cycles after the accept edge; rsp_rdata holds until next response.
REQ-020 busy SHALL be high from the cycle after a read accept through the rsp_valid cycle inclusive.
REQ-021 Write-only request SHALL commit req_wdata[1:0] on the accept edge, produce no rsp_valid and not raise busy.
REQ-022 req_re and req_we together: read-before-write; response returns the old contents, new value committed in same access.
REQ-023 Out-of-range address (x>=X_MAX, y>=Y_MAX or [22:15]!=0): read returns 16'h0001 (wall), write ignored.
REQ-024 CLEAR: write 0 to one cell per cycle, index 0 to X_MAX*Y_MAX-1, busy=1 throughout, clear_done pulses the cycle after the last cell, then IDLE.
REQ-025 clear asserted while in RD_WAIT/RESP SHALL be latched and the sweep starts after the response completes.
REQ-026 clear asserted during CLEAR SHALL be ignored (no restart).

Reset
REQ-027 On reset: rsp_rdata=0, rsp_valid=0, clear_done=0, pending read aborted with no rsp_valid, latched clear dropped.
REQ-028 With TRON_MEM_CLEAR_EN defined, reset exit SHALL enter CLEAR (busy=1 first cycle after reset); without it, reset exit enters IDLE with busy=0.
REQ-029 Reset SHALL not itself modify RAM contents other than through the sweep.

Configuration
REQ-030 Macro TRON_MEM_CLEAR_EN: defined -> CLEAR state, sweep counter, clear and clear_done functional; undefined -> no sweep logic, clear ignored, clear_done tied 0, RAM contents after power-up are device-initialised zero.

Verification
REQ-031 Reset with TRON_MEM_CLEAR_EN, default params -> busy high 19200 cycles, one clear_done pulse, then read (x=10,y=5) -> rsp_valid 2 cycles after accept, rsp_rdata=16'h0000.
REQ-032 Write wdata=16'h0002 to (10,5), then read (10,5) -> rsp_rdata=16'h0002, no rsp_valid on the write.
REQ-033 re=we=1, wdata=16'h0001 on empty (3,3) -> rsp_rdata=16'h0000; subsequent read -> 16'h0001.
REQ-034 Read x=160,y=0 -> 16'h0001; write 16'h0002 to it then read (0,1) -> 16'h0000 (no aliasing).
REQ-035 Second read issued while busy -> dropped, exactly one rsp_valid; resetn low during RD_WAIT -> no rsp_valid, busy follows REQ-028.
REQ-036 Without TRON_MEM_CLEAR_EN: clear pulse -> busy stays 0, clear_done stays 0, written cells retain values.
